// File: rtl/otter_io_ctrl.sv
// rtl/otter_io_ctrl.sv - OTTER IOBUS memory-mapped controller for Basys3 switches, LEDs and seven-segment display
//
// Purpose: decodes IOBUS writes into the LED and seven-segment registers,
// returns read data for the switch/LED/SSEG/status registers, synchronizes
// the raw switches and time-multiplexes the four seven-segment digits.
//
// Ports:
//   CLK        - single clock, all state on posedge
//   RST        - synchronous active-low reset
//   IOBUS_ADDR - MCU address
//   IOBUS_OUT  - MCU write data
//   IOBUS_WR   - MCU write strobe
//   IOBUS_IN   - read data to the MCU (combinational from address + registers)
//   SWITCHES   - raw asynchronous board switches
//   LEDS       - LED drive, active-high
//   ANODES     - digit enables, active-low
//   CATHODES   - segments, active-low, bit 7 = dp, bits 6..0 = g..a
module otter_io_ctrl #(
   parameter int          SCAN_DIV  = 50000,
   parameter logic [31:0] SW_ADDR   = 32'h11000000,
   parameter logic [31:0] LED_ADDR  = 32'h11000020,
   parameter logic [31:0] SSEG_ADDR = 32'h11000040,
   parameter logic [31:0] STAT_ADDR = 32'h11000060
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IOBUS_IN,
   input  logic [15:0] SWITCHES,
   output logic [15:0] LEDS,
   output logic [3:0]  ANODES,
   output logic [7:0]  CATHODES
);

   localparam int                CNT_W   = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [15:0]      r_sw_meta;
   logic [15:0]      r_sw_sync;
   logic [15:0]      r_led;
   logic [19:0]      r_sseg;
   logic [CNT_W-1:0] r_scan_cnt;
   logic [1:0]       r_digit;
   logic [3:0]       r_anodes;
   logic [7:0]       r_cathodes;

   logic [3:0] w_mask;
   logic [3:0] w_nibble;
   logic       w_digit_on;
   logic [3:0] w_anodes_nxt;
   logic [7:0] w_cathodes_nxt;
   logic       w_wr_led;
   logic       w_wr_sseg;
   logic       w_unused;

   // Only the low 20 bits of write data ever land in a register.
   assign w_unused = &{1'b0, IOBUS_OUT[31:20]};

   function automatic logic [6:0] hex7seg(input logic [3:0] v);
      case (v)
         4'h0:    hex7seg = 7'b1000000;
         4'h1:    hex7seg = 7'b1111001;
         4'h2:    hex7seg = 7'b0100100;
         4'h3:    hex7seg = 7'b0110000;
         4'h4:    hex7seg = 7'b0011001;
         4'h5:    hex7seg = 7'b0010010;
         4'h6:    hex7seg = 7'b0000010;
         4'h7:    hex7seg = 7'b1111000;
         4'h8:    hex7seg = 7'b0000000;
         4'h9:    hex7seg = 7'b0010000;
         4'hA:    hex7seg = 7'b0001000;
         4'hB:    hex7seg = 7'b0000011;
         4'hC:    hex7seg = 7'b1000110;
         4'hD:    hex7seg = 7'b0100001;
         4'hE:    hex7seg = 7'b0000110;
         default: hex7seg = 7'b0001110;
      endcase
   endfunction

   assign w_wr_led  = IOBUS_WR && (IOBUS_ADDR == LED_ADDR);
   assign w_wr_sseg = IOBUS_WR && (IOBUS_ADDR == SSEG_ADDR);

   // Current digit's nibble and enable, selected by the scan index.
   assign w_mask     = r_sseg[19:16];
   assign w_nibble   = r_sseg[{r_digit, 2'b00} +: 4];
   assign w_digit_on = w_mask[r_digit];

   always_comb begin
      w_anodes_nxt   = 4'hF;
      w_cathodes_nxt = 8'hFF;
      if (w_digit_on) begin
         w_anodes_nxt   = ~(4'b0001 << r_digit);
         w_cathodes_nxt = {1'b1, hex7seg(w_nibble)};
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_sw_meta <= 16'h0;
         r_sw_sync <= 16'h0;
         r_led     <= 16'h0;
         r_sseg    <= 20'h0;
      end else begin
         r_sw_meta <= SWITCHES;
         r_sw_sync <= r_sw_meta;
         if (w_wr_led)  r_led  <= IOBUS_OUT[15:0];
         if (w_wr_sseg) r_sseg <= IOBUS_OUT[19:0];
      end
   end

   // Scan scheduler plus the display output register; outputs lag the
   // digit index by one cycle.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_scan_cnt <= '0;
         r_digit    <= 2'd0;
         r_anodes   <= 4'hF;
         r_cathodes <= 8'hFF;
      end else begin
         if (r_scan_cnt == CNT_MAX) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         r_anodes   <= w_anodes_nxt;
         r_cathodes <= w_cathodes_nxt;
      end
   end

   always_comb begin
      IOBUS_IN = 32'h0;
      if (IOBUS_ADDR == SW_ADDR)        IOBUS_IN = {16'h0, r_sw_sync};
      else if (IOBUS_ADDR == LED_ADDR)  IOBUS_IN = {16'h0, r_led};
      else if (IOBUS_ADDR == SSEG_ADDR) IOBUS_IN = {12'h0, r_sseg};
      else if (IOBUS_ADDR == STAT_ADDR) IOBUS_IN = {30'h0, r_digit};
   end

   assign LEDS     = r_led;
   assign ANODES   = r_anodes;
   assign CATHODES = r_cathodes;

endmodule

// File: tb/tb_otter_io_ctrl.sv
// tb/tb_otter_io_ctrl.sv - self-checking bench for otter_io_ctrl
module tb_otter_io_ctrl;

   localparam logic [31:0] SW_A   = 32'h11000000;
   localparam logic [31:0] LED_A  = 32'h11000020;
   localparam logic [31:0] SSEG_A = 32'h11000040;
   localparam logic [31:0] STAT_A = 32'h11000060;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] IOBUS_IN;
   logic [15:0] SWITCHES;
   logic [15:0] LEDS;
   logic [3:0]  ANODES;
   logic [7:0]  CATHODES;

   int checks   = 0;
   int failures = 0;

   // Scoreboard of expected {ANODES, CATHODES}, one entry per clock edge.
   logic [11:0] exp_q[$];

   always #5 CLK = ~CLK;

   otter_io_ctrl #(.SCAN_DIV(4)) dut (
      .CLK(CLK), .RST(RST),
      .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
      .IOBUS_IN(IOBUS_IN), .SWITCHES(SWITCHES),
      .LEDS(LEDS), .ANODES(ANODES), .CATHODES(CATHODES)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Reset for 3 edges while toggling LED writes; reset must win.
   task automatic do_reset;
      RST        = 1'b0;
      IOBUS_ADDR = LED_A;
      for (int i = 0; i < 3; i++) begin
         IOBUS_WR  = (i % 2 == 0);
         IOBUS_OUT = $urandom;
         tick();
      end
      IOBUS_WR = 1'b0;
      RST      = 1'b1;
   endtask

   task automatic test_reset;
      SWITCHES = 16'hFFFF;
      do_reset();
      checks++; if (LEDS !== 16'h0) begin failures++; $display("FAIL reset_leds: got %h expected 0000", LEDS); end
      checks++; if (ANODES !== 4'hF) begin failures++; $display("FAIL reset_anodes: got %h expected F", ANODES); end
      checks++; if (CATHODES !== 8'hFF) begin failures++; $display("FAIL reset_cathodes: got %h expected FF", CATHODES); end
      IOBUS_ADDR = STAT_A; #1;
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL reset_stat: got %h expected 0", IOBUS_IN); end
      IOBUS_ADDR = SW_A; #1;
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL reset_sw: got %h expected 0", IOBUS_IN); end
      IOBUS_ADDR = SSEG_A; #1;
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL reset_sseg: got %h expected 0", IOBUS_IN); end
      SWITCHES = 16'h0;
   endtask

   task automatic test_led;
      do_reset();
      IOBUS_ADDR = LED_A; IOBUS_OUT = 32'hFFFF_A5C3; IOBUS_WR = 1'b1; #1;
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL led_same_cycle: got %h expected 0", IOBUS_IN); end
      tick();
      IOBUS_WR = 1'b0;
      checks++; if (LEDS !== 16'hA5C3) begin failures++; $display("FAIL led_write: got %h expected A5C3", LEDS); end
      checks++; if (IOBUS_IN !== 32'h0000A5C3) begin failures++; $display("FAIL led_read: got %h expected 0000A5C3", IOBUS_IN); end
      IOBUS_ADDR = 32'h11000024; IOBUS_OUT = 32'h1234; IOBUS_WR = 1'b1;
      tick();
      IOBUS_WR = 1'b0; #1;
      checks++; if (LEDS !== 16'hA5C3) begin failures++; $display("FAIL led_unmapped_write: got %h expected A5C3", LEDS); end
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h expected 0", IOBUS_IN); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] vals[3] = '{16'h1111, 16'h2222, 16'hBEEF};
      do_reset();
      IOBUS_ADDR = LED_A; IOBUS_WR = 1'b1;
      for (int i = 0; i < 3; i++) begin
         IOBUS_OUT = {16'hDEAD, vals[i]};
         tick();
         checks++; if (LEDS !== vals[i]) begin failures++; $display("FAIL b2b_led[%0d]: got %h expected %h", i, LEDS, vals[i]); end
      end
      IOBUS_WR = 1'b0;
   endtask

   task automatic test_switch;
      do_reset();
      SWITCHES = 16'h8001; IOBUS_ADDR = SW_A;
      tick();
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL sw_one_edge: got %h expected 0", IOBUS_IN); end
      tick();
      checks++; if (IOBUS_IN !== 32'h00008001) begin failures++; $display("FAIL sw_two_edges: got %h expected 00008001", IOBUS_IN); end
      IOBUS_OUT = 32'hFFFF_FFFF; IOBUS_WR = 1'b1;
      tick();
      IOBUS_WR = 1'b0; #1;
      checks++; if (IOBUS_IN !== 32'h00008001) begin failures++; $display("FAIL sw_write_ignored: got %h expected 00008001", IOBUS_IN); end
      checks++; if (LEDS !== 16'h0) begin failures++; $display("FAIL sw_write_led: got %h expected 0000", LEDS); end
      IOBUS_ADDR = SSEG_A; #1;
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL sw_write_sseg: got %h expected 0", IOBUS_IN); end
      SWITCHES = 16'h0;
   endtask

   task automatic test_scan;
      logic [11:0] exp;
      do_reset();
      IOBUS_ADDR = SSEG_A; IOBUS_OUT = 32'h000F_1A80; IOBUS_WR = 1'b1;
      // First edge captures the write while the output stage still shows blank.
      exp_q.push_back({4'hF, 8'hFF});
      for (int k = 0; k < 3; k++) exp_q.push_back({4'hE, 8'hC0});
      for (int k = 0; k < 4; k++) exp_q.push_back({4'hD, 8'h80});
      for (int k = 0; k < 4; k++) exp_q.push_back({4'hB, 8'h88});
      for (int k = 0; k < 4; k++) exp_q.push_back({4'h7, 8'hF9});
      for (int k = 0; k < 4; k++) exp_q.push_back({4'hE, 8'hC0});
      for (int i = 0; i < 20; i++) begin
         tick();
         IOBUS_WR = 1'b0;
         exp = exp_q.pop_front();
         checks++;
         if ({ANODES, CATHODES} !== exp) begin
            failures++;
            $display("FAIL scan[%0d]: got an=%h ca=%h expected an=%h ca=%h", i, ANODES, CATHODES, exp[11:8], exp[7:0]);
         end
      end
      IOBUS_ADDR = STAT_A; #1;
      checks++; if (IOBUS_IN !== 32'h1) begin failures++; $display("FAIL scan_wrap_stat: got %h expected 1", IOBUS_IN); end
   endtask

   task automatic test_blanking;
      logic [11:0] exp;
      do_reset();
      IOBUS_ADDR = SSEG_A; IOBUS_OUT = 32'h0005_00FF; IOBUS_WR = 1'b1;
      exp_q.push_back({4'hF, 8'hFF});
      for (int k = 0; k < 3; k++) exp_q.push_back({4'hE, 8'h8E});
      for (int k = 0; k < 4; k++) exp_q.push_back({4'hF, 8'hFF});
      for (int k = 0; k < 4; k++) exp_q.push_back({4'hB, 8'hC0});
      for (int k = 0; k < 4; k++) exp_q.push_back({4'hF, 8'hFF});
      exp_q.push_back({4'hE, 8'h8E});
      for (int i = 0; i < 17; i++) begin
         tick();
         IOBUS_WR = 1'b0;
         exp = exp_q.pop_front();
         checks++;
         if ({ANODES, CATHODES} !== exp) begin
            failures++;
            $display("FAIL blank[%0d]: got an=%h ca=%h expected an=%h ca=%h", i, ANODES, CATHODES, exp[11:8], exp[7:0]);
         end
      end
   endtask

   task automatic test_reset_mid_scan;
      do_reset();
      IOBUS_ADDR = SSEG_A; IOBUS_OUT = 32'h000F_1A80; IOBUS_WR = 1'b1;
      tick();
      IOBUS_WR = 1'b0;
      // Ten edges since reset: index 2, scan count 2.
      for (int i = 0; i < 9; i++) tick();
      IOBUS_ADDR = STAT_A; #1;
      checks++; if (IOBUS_IN !== 32'h2) begin failures++; $display("FAIL mid_stat_before: got %h expected 2", IOBUS_IN); end
      checks++; if ({ANODES, CATHODES} !== {4'hB, 8'h88}) begin failures++; $display("FAIL mid_display_before: got %h expected B88", {ANODES, CATHODES}); end
      RST = 1'b0; IOBUS_ADDR = LED_A; IOBUS_OUT = 32'h5555; IOBUS_WR = 1'b1;
      tick();
      RST = 1'b1; IOBUS_WR = 1'b0;
      checks++; if (LEDS !== 16'h0) begin failures++; $display("FAIL mid_led: got %h expected 0000", LEDS); end
      checks++; if ({ANODES, CATHODES} !== 12'hFFF) begin failures++; $display("FAIL mid_display_blank: got %h expected FFF", {ANODES, CATHODES}); end
      IOBUS_ADDR = SSEG_A; #1;
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL mid_sseg: got %h expected 0", IOBUS_IN); end
      IOBUS_ADDR = STAT_A; #1;
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL mid_stat_after: got %h expected 0", IOBUS_IN); end
      // A cleared scan count means the index advances exactly 4 edges later.
      for (int i = 0; i < 3; i++) tick();
      checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("FAIL mid_dwell_3: got %h expected 0", IOBUS_IN); end
      tick();
      checks++; if (IOBUS_IN !== 32'h1) begin failures++; $display("FAIL mid_dwell_4: got %h expected 1", IOBUS_IN); end
   endtask

   initial begin
      RST = 1'b0; IOBUS_ADDR = 32'h0; IOBUS_OUT = 32'h0; IOBUS_WR = 1'b0; SWITCHES = 16'h0;
      test_reset();
      test_led();
      test_back_to_back();
      test_switch();
      test_scan();
      test_blanking();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/otter_io_ctrl.md
# otter_io_ctrl

Memory-mapped I/O controller between the OTTER_MCU IOBUS and the Basys3 board I/O. It decodes `IOBUS_ADDR` and synchronizes the switch inputs. It holds the LED and seven-segment registers, returns read data on `IOBUS_IN`, and time-multiplexes the four-digit seven-segment display with a scan scheduler. The MCU sees one fixed register map; the board sees only registered outputs.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: CLK cycles each digit stays lit. Legal range ≥ 2.
- `SW_ADDR`, default 32'h11000000: switch input register (read-only).
- `LED_ADDR`, default 32'h11000020: LED register (read/write).
- `SSEG_ADDR`, default 32'h11000040: seven-segment register (read/write).
- `STAT_ADDR`, default 32'h11000060: status register (read-only).

Ports:
- `CLK`, input, 1: the single clock; everything is posedge.
- `RST`, input, 1: reset, synchronous and active-low.
- `IOBUS_ADDR`, input, 32: address from the MCU.
- `IOBUS_OUT`, input, 32: write data from the MCU.
- `IOBUS_WR`, input, 1: write strobe.
- `IOBUS_IN`, output, 32: read data to the MCU.
- `SWITCHES`, input, 16: raw board switches (asynchronous).
- `LEDS`, output, 16: LED drive, active-high.
- `ANODES`, output, 4: digit enables, active-low.
- `CATHODES`, output, 8: segments, active-low; bit 7 = dp, bits 6..0 = g..a.

## Operation
**Switch synchronizer**
- Two-flop synchronizer: `SWITCHES` → `sw_meta` → `sw_sync`.

**Write decode**
- A write happens on a CLK edge with `IOBUS_WR`=1.
- Exact 32-bit match on `LED_ADDR`: LED register ← `IOBUS_OUT[15:0]`.
- Exact 32-bit match on `SSEG_ADDR`: SSEG register ← `IOBUS_OUT[19:0]`.
  - Bits [15:0] are four hex nibbles; digit 0 = [3:0], the rightmost digit.
  - Bits [19:16] are the per-digit enable mask; a 0 bit blanks that digit.
- Writes to `SW_ADDR`, `STAT_ADDR` or any unmapped address are ignored. No side effects.

**Read mux**
- `IOBUS_IN` is combinational from `IOBUS_ADDR` plus registered state only:
  - `SW_ADDR` → {16'b0, sw_sync}
  - `LED_ADDR` → {16'b0, LED register}
  - `SSEG_ADDR` → {12'b0, SSEG register}
  - `STAT_ADDR` → {30'b0, digit index}
  - unmapped → 32'h0
- `IOBUS_WR` does not affect `IOBUS_IN`.

**Scan scheduler**
- `scan_cnt` counts 0..`SCAN_DIV`-1. Width is $clog2(`SCAN_DIV`).
- When `scan_cnt` = `SCAN_DIV`-1: `scan_cnt` ← 0 and digit index ← index+1, mod 4 (wraps 3→0).
- Output stage, registered every cycle from the current digit index d:
  - `ANODES` ← ~(4'b0001 << d) if mask[d]=1, else 4'b1111.
  - `CATHODES` ← {1'b1, hex7seg(nibble d)} if mask[d]=1, else 8'hFF.
- hex7seg is the standard active-low 0–F table:
  - 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, A = 7'b0001000, F = 7'b0001110.
- dp is always off (1).

**Reset** (`RST`=0 at an edge; takes priority over writes and scanning)
- LED register = 0, SSEG register = 0, digit index = 0, `scan_cnt` = 0, synchronizer flops = 0.
- Outputs: `LEDS` = 16'h0000, `ANODES` = 4'hF, `CATHODES` = 8'hFF.
- `IOBUS_IN` = 32'h0 for any mapped read, since every source is zeroed.
- Reset asserted mid-scan or mid-write aborts cleanly. No partial state survives.

## Timing
- Write → `LEDS`: visible on the edge that captures the write. Latency 1 cycle from the `IOBUS_WR` cycle.
- Write → SSEG register: 1 cycle. Write → `ANODES`/`CATHODES`: 2 cycles, because of the output register.
- Register read-back: the value is readable on `IOBUS_IN` in the cycle after the write edge. Same-cycle read returns the old value.
- `SWITCHES` → `IOBUS_IN`: 2 edges through the synchronizer, then combinational.
- Digit dwell: exactly `SCAN_DIV` cycles per digit. Full refresh = 4×`SCAN_DIV` cycles.
- Digit index change → `ANODES`/`CATHODES` change: 1 cycle later.
- Simultaneous reset and write: reset wins; the register reads 0.
- Back-to-back writes to the same register: the last write wins, one per cycle.

## Test plan
- **Reset:** hold `RST`=0 for 3 cycles, toggling `IOBUS_WR` with `LED_ADDR`. Expect `LEDS`=0, `ANODES`=4'hF, `CATHODES`=8'hFF, read of `STAT_ADDR` = 0.
- **LED write/readback:** write 32'hFFFF_A5C3 to `LED_ADDR`.
  - Next cycle: `LEDS`=16'hA5C3, `IOBUS_IN` at `LED_ADDR` = 32'h0000A5C3.
  - Write 32'h1234 to 32'h11000024 (unmapped): `LEDS` unchanged, and a read of that address = 0.
- **Switch sync:** drive `SWITCHES`=16'h8001.
  - `IOBUS_IN` at `SW_ADDR` = 0 after 1 edge, = 32'h00008001 after 2 edges.
  - A write to `SW_ADDR` has no effect.
- **Scan** (`SCAN_DIV`=4): write 32'h000F_1A80 to `SSEG_ADDR`.
  - `ANODES` cycles E,D,B,7, each held 4 cycles.
  - `CATHODES` cycles C0 (0), 80 (8), 88 (A), F9 (1).
  - Index wraps 3→0.
- **Blanking:** write 32'h0005_00FF (mask 4'b0101). Digits 1 and 3 give `ANODES`=F, `CATHODES`=FF; digit 0 shows F (8E), digit 2 shows 0 (C0).
- **Reset mid-scan:** assert `RST` at digit index 2 with `scan_cnt`=2. Next edge: index 0, `scan_cnt` 0, display blank, SSEG reads 0.
